// File: rtl/letc_core_pkg.sv
// Shared types for the LETC core cache slice.
package letc_core_pkg;

  typedef logic [31:0] word_t;
  typedef logic [31:0] paddr_t;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    DONE
  } cache_state_e;

endpackage

// File: rtl/letc_core_cache_refill.sv
// Miss handling for letc_core_cache: FSM, beat counter, poison flag and
// LIMP refill address generation.
module letc_core_cache_refill
  import letc_core_pkg::*;
#(
  parameter int unsigned CACHE_DEPTH      = 64,
  parameter int unsigned CACHE_LINE_WORDS = 4,
  localparam int unsigned BEAT_W          = $clog2(CACHE_LINE_WORDS),
  localparam int unsigned LINE_W          = 32 - BEAT_W - 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stage_valid,
  input  logic              i_hit,
  input  logic              i_flush,
  input  logic [LINE_W-1:0] i_req_line,
  input  logic              i_limp_ready,
  output cache_state_e      o_state,
  output logic [BEAT_W-1:0] o_beat,
  output logic [LINE_W-1:0] o_line,
  output logic              o_data_we,
  output logic              o_tag_we,
  output logic              o_set_valid,
  output logic              o_limp_valid,
  output paddr_t            o_limp_addr
);

  cache_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              poison_q, poison_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      line_q   <= '0;
      poison_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      line_q   <= line_d;
      poison_q <= poison_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    line_d       = line_q;
    poison_d     = poison_q;
    o_data_we    = 1'b0;
    o_tag_we     = 1'b0;
    o_set_valid  = 1'b0;
    o_limp_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_stage_valid && !i_hit && !i_flush) begin
          state_d = REFILL;
          line_d  = i_req_line;
          beat_d  = '0;
        end
      end
      REFILL: begin
        o_limp_valid = 1'b1;
        if (i_flush) poison_d = 1'b1;
        if (i_limp_ready) begin
          o_data_we = 1'b1;
          beat_d    = beat_q + 1'b1;
          if (&beat_q) state_d = DONE;
        end
      end
      DONE: begin
        // A flush landing in this cycle also keeps the line invalid.
        o_tag_we    = 1'b1;
        o_set_valid = !poison_q && !i_flush;
        poison_d    = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_state     = state_q;
  assign o_beat      = beat_q;
  assign o_line      = line_q;
  assign o_limp_addr = {line_q, beat_q, 2'b00};

endmodule

// File: rtl/letc_core_cache.sv
// Read-only direct-mapped blocking cache for a LETC pipeline stage, with
// line refill over a LIMP read port and single-cycle flush.
module letc_core_cache
  import letc_core_pkg::*;
#(
  parameter int unsigned CACHE_DEPTH      = 64,
  parameter int unsigned CACHE_LINE_WORDS = 4
) (
  input  logic   i_clk,
  input  logic   i_rst,
  input  logic   i_stage_valid,
  input  paddr_t i_stage_addr,
  output logic   o_stage_ready,
  output word_t  o_stage_rdata,
  input  logic   i_flush,
  output logic   o_limp_valid,
  output paddr_t o_limp_addr,
  input  logic   i_limp_ready,
  input  word_t  i_limp_rdata
);

  localparam int unsigned BEAT_W   = $clog2(CACHE_LINE_WORDS);
  localparam int unsigned OFFSET_W = BEAT_W + 2;
  localparam int unsigned INDEX_W  = $clog2(CACHE_DEPTH);
  localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W;
  localparam int unsigned LINE_W   = 32 - OFFSET_W;

  logic [CACHE_DEPTH-1:0] valid_q;
  logic [TAG_W-1:0]       tag_q  [CACHE_DEPTH];
  word_t                  data_q [CACHE_DEPTH][CACHE_LINE_WORDS];

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_index;
  logic [BEAT_W-1:0]  req_word;
  logic [LINE_W-1:0]  req_line;
  logic               unused_addr_bits;

  assign req_line         = i_stage_addr[31:OFFSET_W];
  assign req_tag          = i_stage_addr[31 -: TAG_W];
  assign req_index        = i_stage_addr[OFFSET_W +: INDEX_W];
  assign req_word         = i_stage_addr[2 +: BEAT_W];
  assign unused_addr_bits = ^i_stage_addr[1:0];

  cache_state_e       state;
  logic [BEAT_W-1:0]  beat;
  logic [LINE_W-1:0]  line;
  logic               data_we, tag_we, set_valid, hit;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;

  assign fill_index = line[0 +: INDEX_W];
  assign fill_tag   = line[LINE_W-1 -: TAG_W];

  assign hit = (state == IDLE) && i_stage_valid && valid_q[req_index] &&
               (tag_q[req_index] == req_tag);

  assign o_stage_ready = hit;
  assign o_stage_rdata = hit ? data_q[req_index][req_word] : '0;

  letc_core_cache_refill #(
    .CACHE_DEPTH      (CACHE_DEPTH),
    .CACHE_LINE_WORDS (CACHE_LINE_WORDS)
  ) u_refill (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_stage_valid (i_stage_valid),
    .i_hit         (hit),
    .i_flush       (i_flush),
    .i_req_line    (req_line),
    .i_limp_ready  (i_limp_ready),
    .o_state       (state),
    .o_beat        (beat),
    .o_line        (line),
    .o_data_we     (data_we),
    .o_tag_we      (tag_we),
    .o_set_valid   (set_valid),
    .o_limp_valid  (o_limp_valid),
    .o_limp_addr   (o_limp_addr)
  );

  // The valid bit is rewritten on completion so a poisoned refill can never
  // leave a stale valid bit paired with the new tag.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= '0;
    end else if (i_flush) begin
      valid_q <= '0;
    end else if (tag_we) begin
      valid_q[fill_index] <= set_valid;
    end
  end

  always_ff @(posedge i_clk) begin
    if (data_we) data_q[fill_index][beat] <= i_limp_rdata;
    if (tag_we)  tag_q[fill_index]        <= fill_tag;
  end

endmodule

// File: doc/letc_core_cache.md
# letc_core_cache

Read-only, direct-mapped, blocking cache that answers requests from a LETC core pipeline stage (fetch or memory) on the stage side of the core cache interface. Misses are refilled one line at a time over a LIMP-style valid/ready read port toward the memory subsystem. Hits complete in the same cycle. A flush input invalidates every line, e.g. for FENCE.I.

## Interface
- CACHE_DEPTH, 64: number of lines; power of two, ≥2
- CACHE_LINE_WORDS, 4: 32-bit words per line; power of two, ≥2

- i_clk  in  1  core clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_stage_valid  in  1  stage read request; held with i_stage_addr until o_stage_ready
- i_stage_addr  in  32  byte address; bits [1:0] ignored (word access)
- o_stage_ready  out  1  request completes this cycle; o_stage_rdata valid
- o_stage_rdata  out  32  read data
- i_flush  in  1  invalidate all lines (single-cycle pulse or level)
- o_limp_valid  out  1  refill word read request
- o_limp_addr  out  32  word-aligned refill address
- i_limp_ready  in  1  i_limp_rdata valid; current beat accepted
- i_limp_rdata  in  32  refill data word

## Operation
- Address split: offset = log2(CACHE_LINE_WORDS)+2 bits, index = log2(CACHE_DEPTH) bits, tag = remaining upper bits.
- Per line storage: valid bit, tag, CACHE_LINE_WORDS data words.
- FSM states: IDLE, REFILL, DONE.
- IDLE:
  - i_stage_valid with a valid line whose tag matches is a hit: o_stage_ready=1 combinationally, rdata = the addressed word.
  - Otherwise it is a miss: latch line base address (tag, index), clear beat counter, go to REFILL.
  - No miss is taken while i_flush=1; flush wins that cycle.
- REFILL:
  - o_limp_valid=1; o_limp_addr = {tag, index, beat, 2'b00}.
  - Each cycle with i_limp_ready: write i_limp_rdata to data[index][beat], increment beat.
  - On the last beat (beat == CACHE_LINE_WORDS-1 && i_limp_ready), go to DONE.
- DONE (one cycle):
  - Write tag; set valid unless the poison flag is set.
  - Clear poison; return to IDLE. The held request then hits, or re-misses if the line was poisoned.
- Flush:
  - i_flush clears all valid bits at the next edge.
  - If asserted during REFILL or DONE, set poison; the refill still completes all beats (no LIMP abort) but the line stays invalid.
- o_stage_ready is 0 in REFILL and DONE.
- Deasserting i_stage_valid mid-refill is illegal; the refill completes regardless and no response is given.
- The beat counter wraps to 0 after the last beat. Tag and index are latched, so later changes to i_stage_addr during REFILL do not affect refill addresses.

## Timing
- Reset values: FSM=IDLE, all valid=0, poison=0, beat=0, o_limp_valid=0, o_limp_addr=0, o_stage_ready=0, o_stage_rdata=0. Data and tag arrays are not reset.
- Hit latency: 0 cycles (combinational from request to ready).
- Miss, with i_limp_ready held high: miss at cycle 0, REFILL beats in cycles 1..N, DONE in N+1, hit in N+2 (N = CACHE_LINE_WORDS).
- LIMP: o_limp_valid/o_limp_addr stay stable until i_limp_ready; one word per ready cycle; back-to-back beats allowed.
- Reset asserted mid-refill: immediately IDLE, o_limp_valid=0, partial line stays invalid.

## Structure
- letc_core_pkg: word_t (32b), paddr_t (32b), and a cache_state_e enum (IDLE/REFILL/DONE). Tag, index and offset widths are derived locally from the parameters.
- Valid bits live in flops (single-cycle flush). Tag and data arrays are flop arrays, with no synchronous SRAM assumption.
- One sub-module is natural: letc_core_cache_refill, holding the FSM, beat counter, poison flag and LIMP address generation.

## Test plan
- Cold miss at 0x0000_1004 with ready always high → LIMP addresses 0x1000, 0x1004, 0x1008, 0x100C in cycles 1-4; o_stage_ready in cycle 6 with the word returned for 0x1004.
- Warm hit after a fill: requests to 0x1000..0x100C → ready in the same cycle, correct data, o_limp_valid stays 0.
- Conflict: fill 0x1000, then request 0x1000 + CACHE_DEPTH*16 (0x1400 with defaults) → miss and refill; a re-request of 0x1000 misses again.
- Flush during beat 2 of a refill → all 4 beats still issue; line invalid; the held request re-misses and refills, then hits.
- LIMP stalls: ready low for 3 cycles before each beat → o_limp_addr stable throughout the stall; correct data after the refill.
- Reset asserted mid-REFILL → o_limp_valid=0 asynchronously; after release, the same address misses.
